// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: idle/countdown/run/pause/over/clear FSM that
// gates the game logic, paces the obstacle scroll and keeps score/level.
//
// Ports:
//   clk, rst (async, active-low)
//   key_star           start/pause key (level, debounced)
//   collision_detected collision flag from the game logic
//   run_game           high only while running
//   scroll_tick        one-cycle obstacle-advance pulse
//   level, score       display values (score saturates at 9999)
//   countdown          3,2,1 during the countdown, else 0
//   state              IDLE=0 COUNTDOWN=1 RUN=2 PAUSE=3 OVER=4 CLEAR=5
//   game_over          high in OVER
//   game_clear         high in CLEAR
module game_flow_ctrl #(
    parameter int unsigned BASE_DIV        = 1_000_000,
    parameter int unsigned DIV_STEP        = 100_000,
    parameter int unsigned MAX_LEVEL       = 7,
    parameter int unsigned STEPS_PER_LEVEL = 32,
    parameter int unsigned COUNT_DIV       = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_star,
    input  logic        collision_detected,
    output logic        run_game,
    output logic        scroll_tick,
    output logic [2:0]  level,
    output logic [13:0] score,
    output logic [1:0]  countdown,
    output logic [2:0]  state,
    output logic        game_over,
    output logic        game_clear
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    state_t      cur;
    logic        star_q;
    logic        star_ev;
    logic [25:0] div_cnt;
    logic [25:0] timer;
    logic [25:0] period;
    logic [5:0]  steps;
    logic [5:0]  steps_inc;

    assign star_ev   = key_star & ~star_q;
    // Scroll period shrinks linearly with level.
    assign period    = 26'(BASE_DIV) - 26'(DIV_STEP) * 26'(level);
    assign steps_inc = steps + 6'd1;
    assign state     = cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= S_IDLE;
            star_q      <= 1'b1;
            div_cnt     <= '0;
            timer       <= '0;
            steps       <= '0;
            score       <= '0;
            level       <= '0;
            countdown   <= '0;
            run_game    <= 1'b0;
            scroll_tick <= 1'b0;
            game_over   <= 1'b0;
            game_clear  <= 1'b0;
        end else begin
            star_q      <= key_star;
            scroll_tick <= 1'b0;
            unique case (cur)
                S_IDLE, S_OVER, S_CLEAR: begin
                    if (star_ev) begin
                        cur        <= S_COUNT;
                        game_over  <= 1'b0;
                        game_clear <= 1'b0;
                        score      <= '0;
                        level      <= '0;
                        steps      <= '0;
                        div_cnt    <= '0;
                        timer      <= '0;
                        countdown  <= 2'd3;
                    end
                end
                S_COUNT: begin
                    if (timer == 26'(COUNT_DIV - 1)) begin
                        timer <= '0;
                        if (countdown == 2'd1) begin
                            cur       <= S_RUN;
                            run_game  <= 1'b1;
                            countdown <= '0;
                        end else begin
                            countdown <= countdown - 2'd1;
                        end
                    end else begin
                        timer <= timer + 26'd1;
                    end
                end
                S_RUN: begin
                    if (collision_detected) begin
                        cur       <= S_OVER;
                        run_game  <= 1'b0;
                        game_over <= 1'b1;
                    end else if (star_ev) begin
                        // Divider holds so the period resumes where it left off.
                        cur      <= S_PAUSE;
                        run_game <= 1'b0;
                    end else if (div_cnt == period - 26'd1) begin
                        scroll_tick <= 1'b1;
                        div_cnt     <= '0;
                        if (score != 14'd9999)
                            score <= score + 14'd1;
                        if (steps_inc == 6'(STEPS_PER_LEVEL)) begin
                            steps <= '0;
                            if (level < 3'(MAX_LEVEL)) begin
                                level <= level + 3'd1;
                            end else begin
                                cur        <= S_CLEAR;
                                run_game   <= 1'b0;
                                game_clear <= 1'b1;
                            end
                        end else begin
                            steps <= steps_inc;
                        end
                    end else begin
                        div_cnt <= div_cnt + 26'd1;
                    end
                end
                S_PAUSE: begin
                    if (star_ev) begin
                        cur      <= S_RUN;
                        run_game <= 1'b1;
                    end
                end
                default: begin
                    cur        <= S_IDLE;
                    run_game   <= 1'b0;
                    game_over  <= 1'b0;
                    game_clear <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed key/collision vectors with a
// tick-count based reference model compared every cycle.
module tb_game_flow_ctrl;

    localparam int BASE = 10;
    localparam int STEP = 2;
    localparam int MAXL = 3;
    localparam int SPL  = 4;
    localparam int CDIV = 5;

    logic        clk;
    logic        rst;
    logic        key_star;
    logic        collision_detected;
    logic        run_game;
    logic        scroll_tick;
    logic [2:0]  level;
    logic [13:0] score;
    logic [1:0]  countdown;
    logic [2:0]  state;
    logic        game_over;
    logic        game_clear;

    int errors = 0;
    int checks = 0;

    game_flow_ctrl #(
        .BASE_DIV(BASE),
        .DIV_STEP(STEP),
        .MAX_LEVEL(MAXL),
        .STEPS_PER_LEVEL(SPL),
        .COUNT_DIV(CDIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_star(key_star),
        .collision_detected(collision_detected),
        .run_game(run_game),
        .scroll_tick(scroll_tick),
        .level(level),
        .score(score),
        .countdown(countdown),
        .state(state),
        .game_over(game_over),
        .game_clear(game_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the game is described by the number of ticks
    // survived, progress cycles into the current period and cycles left
    // in the countdown; level, score and digit are derived from those.
    int m_state, m_ticks, m_prog, m_left, m_tick, m_prev;
    logic m_ev;

    function automatic int m_level();
        return (m_ticks / SPL > MAXL) ? MAXL : m_ticks / SPL;
    endfunction

    function automatic int m_score();
        return (m_ticks > 9999) ? 9999 : m_ticks;
    endfunction

    function automatic int m_cd();
        return (m_state == 1) ? (m_left + CDIV - 1) / CDIV : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0;
            m_ticks = 0;
            m_prog  = 0;
            m_left  = 0;
            m_tick  = 0;
            m_prev  = 1;
        end else begin
            m_ev   = key_star && (m_prev == 0);
            m_prev = int'(key_star);
            m_tick = 0;
            case (m_state)
                0, 4, 5: if (m_ev) begin
                    m_state = 1;
                    m_ticks = 0;
                    m_prog  = 0;
                    m_left  = 3 * CDIV;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                2: begin
                    if (collision_detected) m_state = 4;
                    else if (m_ev) m_state = 3;
                    else begin
                        m_prog++;
                        if (m_prog == BASE - STEP * m_level()) begin
                            m_prog = 0;
                            m_tick = 1;
                            m_ticks++;
                            if (m_ticks == SPL * (MAXL + 1)) m_state = 5;
                        end
                    end
                end
                3: if (m_ev) m_state = 2;
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("state", int'(state), m_state);
            check("run_game", int'(run_game), int'(m_state == 2));
            check("game_over", int'(game_over), int'(m_state == 4));
            check("game_clear", int'(game_clear), int'(m_state == 5));
            check("scroll_tick", int'(scroll_tick), m_tick);
            check("score", int'(score), m_score());
            check("level", int'(level), m_level());
            check("countdown", int'(countdown), m_cd());
        end
    end

    task automatic press();
        @(posedge clk);
        #2 key_star = 1'b1;
        @(posedge clk);
        #2 key_star = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2 n++;
        end while (!scroll_tick && n < 200);
        if (!scroll_tick) check("tick_timeout", n, -1);
    endtask

    task automatic wait_run(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2 n++;
        end while (!run_game && n < 100);
        if (!run_game) check("run_timeout", n, -1);
    endtask

    int n;
    int ticks_seen;

    initial begin
        rst = 1'b0;
        key_star = 1'b0;
        collision_detected = 1'b0;
        #23;
        check("rst_state", int'(state), 0);
        check("rst_score", int'(score), 0);
        rst = 1'b1;

        // Countdown digits and length.
        press();
        check("cd_entry_state", int'(state), 1);
        check("cd_entry_digit", int'(countdown), 3);
        n = 0;
        do begin
            @(posedge clk);
            #2 n++;
            if (n == 4) check("cd_digit_n4", int'(countdown), 3);
            if (n == 5) check("cd_digit_n5", int'(countdown), 2);
            if (n == 10) check("cd_digit_n10", int'(countdown), 1);
        end while (!run_game && n < 100);
        check("cd_length", n, 15);
        check("run_state", int'(state), 2);

        // Level 0 period, level-up after 4 ticks, faster period after.
        for (int k = 1; k <= 4; k++) begin
            wait_tick(n);
            check("l0_period", n, 10);
        end
        check("lvl_after4", int'(level), 1);
        check("score_after4", int'(score), 4);
        wait_tick(n);
        check("l1_period", n, 8);

        // Collision on the cycle the divider hits P-1.
        repeat (7) @(posedge clk);
        #2 collision_detected = 1'b1;
        @(posedge clk);
        #2 collision_detected = 1'b0;
        check("coll_state", int'(state), 4);
        check("coll_over", int'(game_over), 1);
        check("coll_run", int'(run_game), 0);
        check("coll_tick", int'(scroll_tick), 0);
        check("coll_score", int'(score), 5);
        press();
        check("restart_state", int'(state), 1);
        check("restart_score", int'(score), 0);
        check("restart_level", int'(level), 0);
        wait_run(n);
        check("cd_length2", n, 15);

        // Pause with divider at 6, collision ignored, resume.
        repeat (6) @(posedge clk);
        #2 key_star = 1'b1;
        @(posedge clk);
        #2 key_star = 1'b0;
        check("pause_state", int'(state), 3);
        ticks_seen = 0;
        for (int c = 0; c < 100; c++) begin
            collision_detected = (c >= 50 && c < 60);
            @(posedge clk);
            #2;
            if (scroll_tick) ticks_seen++;
        end
        collision_detected = 1'b0;
        check("pause_ticks", ticks_seen, 0);
        check("pause_hold", int'(state), 3);
        press();
        check("resume_state", int'(state), 2);
        wait_tick(n);
        check("resume_first", n, 4);

        // Run through all levels to CLEAR.
        for (int k = 2; k <= 16; k++) begin
            wait_tick(n);
            check("period_lvl", n, 10 - 2 * ((k - 1) / 4));
        end
        check("clear_state", int'(state), 5);
        check("clear_flag", int'(game_clear), 1);
        check("clear_score", int'(score), 16);
        check("clear_level", int'(level), 3);
        ticks_seen = 0;
        repeat (50) begin
            @(posedge clk);
            #2;
            if (scroll_tick) ticks_seen++;
        end
        check("clear_no_ticks", ticks_seen, 0);

        // Asynchronous reset mid-RUN, key held through release.
        press();
        wait_run(n);
        repeat (13) @(posedge clk);
        #3 key_star = 1'b1;
        rst = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_run", int'(run_game), 0);
        check("arst_score", int'(score), 0);
        check("arst_level", int'(level), 0);
        check("arst_cd", int'(countdown), 0);
        check("arst_tick", int'(scroll_tick), 0);
        check("arst_flags", int'({game_over, game_clear}), 0);
        #12 rst = 1'b1;
        repeat (10) @(posedge clk);
        #2 check("held_key_idle", int'(state), 0);
        key_star = 1'b0;
        press();
        check("repress_state", int'(state), 1);
        repeat (5) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
